// File: rtl/soc_pkg.sv
// rtl/soc_pkg.sv - shared FSM state type, widths and default SoC memory map
package soc_pkg;

  // Bus decoder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DERR = 2'd2
  } wb_state_e;

  // Slave index width covers up to 8 slaves; wait counter covers TIMEOUT up to 65535
  localparam int IDX_W = 3;
  localparam int CNT_W = 16;

  // Default memory map: slave 0 = RAM, slave 1 = GPIO
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] RAM_SIZE  = 32'h0000_0800;
  localparam logic [31:0] GPIO_BASE = 32'h4000_0000;
  localparam logic [31:0] GPIO_SIZE = 32'h0000_1000;

  // Power-of-two region size to address match mask
  function automatic logic [31:0] size_to_mask(input logic [31:0] size);
    return ~(size - 32'd1);
  endfunction

  localparam logic [31:0] RAM_MASK  = size_to_mask(RAM_SIZE);
  localparam logic [31:0] GPIO_MASK = size_to_mask(GPIO_SIZE);

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational address-hit priority encoder
//
// Ports:
//   i_adr  : 32-bit request address
//   o_hit  : high when any slave region matches (adr & mask) == base
//   o_idx  : index of the lowest-numbered matching slave (0 when no hit)
module wb_addr_decode
  import soc_pkg::*;
#(
  parameter int                      N_SLAVES   = 2,
  parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {GPIO_BASE, RAM_BASE},
  parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {GPIO_MASK, RAM_MASK}
) (
  input  logic [31:0]      i_adr,
  output logic             o_hit,
  output logic [IDX_W-1:0] o_idx
);

  // Scan from the highest index down so the lowest matching index is the
  // last assignment and therefore wins on overlapping regions.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((i_adr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        o_hit = 1'b1;
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_decoder.sv
// rtl/wb_decoder.sv - Wishbone single-master to N-slave address decoder with timeout
//
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   m_cyc_i .. m_we_i        : master request (address, byte select, write data, direction)
//   m_dat_o, m_ack_o,
//   m_err_o, m_rty_o         : response to master (selected slave, or decode/timeout error)
//   s_cyc_o, s_stb_o         : per-slave cycle/strobe, only the decoded slave is strobed
//   s_adr_o .. s_we_o        : request fan-out, shared by all slaves
//   s_dat_i, s_ack_i,
//   s_err_i, s_rty_i         : per-slave responses, only the decoded slave is observed
module wb_decoder
  import soc_pkg::*;
#(
  parameter int                      N_SLAVES   = 2,
  parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {GPIO_BASE, RAM_BASE},
  parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {GPIO_MASK, RAM_MASK},
  parameter int                      TIMEOUT    = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     m_cyc_i,
  input  logic                     m_stb_i,
  input  logic [31:0]              m_adr_i,
  input  logic [3:0]               m_sel_i,
  input  logic [31:0]              m_dat_i,
  input  logic                     m_we_i,
  output logic [31:0]              m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic                     m_rty_o,
  output logic [N_SLAVES-1:0]      s_cyc_o,
  output logic [N_SLAVES-1:0]      s_stb_o,
  output logic [31:0]              s_adr_o,
  output logic [3:0]               s_sel_o,
  output logic [31:0]              s_dat_o,
  output logic                     s_we_o,
  input  logic [N_SLAVES*32-1:0]   s_dat_i,
  input  logic [N_SLAVES-1:0]      s_ack_i,
  input  logic [N_SLAVES-1:0]      s_err_i,
  input  logic [N_SLAVES-1:0]      s_rty_i
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  wb_state_e        r_state;
  logic [IDX_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;

  logic                w_hit;
  logic [IDX_W-1:0]    w_dec_idx;
  logic                w_active;
  logic                w_fwd;
  logic                w_timeout;
  logic                w_live;
  logic [N_SLAVES-1:0] w_onehot;
  logic                w_sel_ack;
  logic                w_sel_err;
  logic                w_sel_rty;
  logic [31:0]         w_sel_dat;
  logic                w_resp;

  wb_addr_decode #(
    .N_SLAVES   (N_SLAVES),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_addr_decode (
    .i_adr (m_adr_i),
    .o_hit (w_hit),
    .o_idx (w_dec_idx)
  );

  // Request fan-out is a straight passthrough
  assign s_adr_o = m_adr_i;
  assign s_sel_o = m_sel_i;
  assign s_dat_o = m_dat_i;
  assign s_we_o  = m_we_i;

  assign w_active  = m_cyc_i & m_stb_i;
  assign w_fwd     = (r_state == ST_FWD);
  assign w_timeout = (r_cnt == TO_VAL);
  // The slave link is open only while forwarding, the master is requesting
  // and the wait budget has not run out.
  assign w_live    = w_fwd & w_active & ~w_timeout;

  // Mux out the registered slave's responses; the others are never looked at
  always_comb begin
    w_onehot  = '0;
    w_sel_ack = 1'b0;
    w_sel_err = 1'b0;
    w_sel_rty = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_sel_ack   = s_ack_i[i];
        w_sel_err   = s_err_i[i];
        w_sel_rty   = s_rty_i[i];
        w_sel_dat   = s_dat_i[i*32 +: 32];
      end
    end
  end

  assign w_resp = w_sel_ack | w_sel_err | w_sel_rty;

  assign s_cyc_o = w_live ? w_onehot : '0;
  assign s_stb_o = w_live ? w_onehot : '0;

  assign m_ack_o = w_live & w_sel_ack;
  assign m_rty_o = w_live & w_sel_rty;
  // Decode/timeout error is withdrawn if the master abandons the cycle
  assign m_err_o = (w_live & w_sel_err) | ((r_state == ST_DERR) & m_cyc_i);
  assign m_dat_o = (w_live & w_resp) ? w_sel_dat : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_active) begin
            if (w_hit) begin
              r_idx   <= w_dec_idx;
              r_state <= ST_FWD;
            end else begin
              r_state <= ST_DERR;
            end
          end
        end
        ST_FWD: begin
          if (!m_cyc_i) begin
            r_state <= ST_IDLE;
          end else if (w_timeout) begin
            r_state <= ST_DERR;
          end else if (w_live & w_resp) begin
            r_state <= ST_IDLE;
          end else if (w_active) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DERR: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decoder.sv
// tb/tb_wb_decoder.sv - self-checking bench for wb_decoder
module tb_wb_decoder;
  import soc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m_cyc, m_stb, m_we;
  logic [31:0] m_adr, m_dat_w;
  logic [3:0]  m_sel;
  logic [31:0] m_dat_r;
  logic        m_ack, m_err, m_rty;
  logic [1:0]  s_cyc, s_stb;
  logic [31:0] s_adr, s_dat_w;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [63:0] s_dat_r;
  logic [1:0]  s_ack, s_err, s_rty;

  // Second instance with overlapping regions, slaves always acknowledge
  logic [31:0] o_m_dat;
  logic        o_m_ack, o_m_err, o_m_rty;
  logic [1:0]  o_s_cyc, o_s_stb;
  logic [31:0] o_s_adr, o_s_dat;
  logic [3:0]  o_s_sel;
  logic        o_s_we;
  logic [63:0] o_s_dat_i = 64'h0;
  logic [1:0]  o_s_ack_i = 2'b11;
  logic [1:0]  o_s_err_i = 2'b00;
  logic [1:0]  o_s_rty_i = 2'b00;

  wb_decoder #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr), .m_sel_i(m_sel),
    .m_dat_i(m_dat_w), .m_we_i(m_we),
    .m_dat_o(m_dat_r), .m_ack_o(m_ack), .m_err_o(m_err), .m_rty_o(m_rty),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_adr_o(s_adr), .s_sel_o(s_sel),
    .s_dat_o(s_dat_w), .s_we_o(s_we),
    .s_dat_i(s_dat_r), .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty)
  );

  wb_decoder #(
    .N_SLAVES(2),
    .SLAVE_BASE({32'h1000_0000, 32'h1000_0000}),
    .SLAVE_MASK({32'hFFFF_0000, 32'hFFFF_F000}),
    .TIMEOUT(4)
  ) dut_ovl (
    .clk_i(clk), .rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_adr_i(m_adr), .m_sel_i(m_sel),
    .m_dat_i(m_dat_w), .m_we_i(m_we),
    .m_dat_o(o_m_dat), .m_ack_o(o_m_ack), .m_err_o(o_m_err), .m_rty_o(o_m_rty),
    .s_cyc_o(o_s_cyc), .s_stb_o(o_s_stb), .s_adr_o(o_s_adr), .s_sel_o(o_s_sel),
    .s_dat_o(o_s_dat), .s_we_o(o_s_we),
    .s_dat_i(o_s_dat_i), .s_ack_i(o_s_ack_i), .s_err_i(o_s_err_i), .s_rty_i(o_s_rty_i)
  );

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [1:0]  sack, serr, srty;
    logic [31:0] sdat0, sdat1;
    logic [1:0]  exp_stb;
    logic        exp_ack, exp_err, exp_rty;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[9];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic bus_idle();
    m_cyc = 1'b0; m_stb = 1'b0;
    s_ack = '0; s_err = '0; s_rty = '0; s_dat_r = '0;
  endtask

  task automatic request(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    m_adr = adr; m_we = we; m_dat_w = dat; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    //             adr            we  wdat          sack   serr   srty   sdat0         sdat1         stb    ack   err   rty   dat
    vecs[0] = '{32'h1000_0004, 0, 32'h0,        2'b01, 2'b10, 2'b00, 32'hDEAD_BEEF, 32'hBAD0_BAD0, 2'b01, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{32'h1000_07FC, 1, 32'h0000_00A5, 2'b01, 2'b00, 2'b00, 32'h0,        32'h0,        2'b01, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{32'h1000_0800, 0, 32'h0,        2'b11, 2'b00, 2'b00, 32'h1234_5678, 32'h8765_4321, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[3] = '{32'h4000_0000, 1, 32'h0000_0003, 2'b11, 2'b00, 2'b00, 32'hFFFF_FFFF, 32'h0,        2'b10, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4] = '{32'h4000_0FFC, 0, 32'h0,        2'b00, 2'b01, 2'b10, 32'h1111_1111, 32'h0000_5A5A, 2'b10, 1'b0, 1'b0, 1'b1, 32'h0000_5A5A};
    vecs[5] = '{32'h4000_1000, 0, 32'h0,        2'b11, 2'b11, 2'b00, 32'h1, 32'h2,                 2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6] = '{32'h1000_0010, 0, 32'h0,        2'b10, 2'b01, 2'b00, 32'hCAFE_F00D, 32'h9999_9999, 2'b01, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D};
    vecs[7] = '{32'h0FFF_FFFC, 0, 32'h0,        2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[8] = '{32'h2000_0000, 1, 32'h0000_0077, 2'b00, 2'b00, 2'b00, 32'h0,        32'h0,        2'b00, 1'b0, 1'b1, 1'b0, 32'h0};

    // Reset state, fan-out still passes through
    rst_n = 1'b0;
    bus_idle();
    m_adr = 32'h1234_5678; m_dat_w = 32'hA5A5_5A5A; m_sel = 4'h6; m_we = 1'b1;
    step(); settle();
    chk("rst_s_cyc", s_cyc, 2'b00);
    chk("rst_s_stb", s_stb, 2'b00);
    chk("rst_m_resp", {m_ack, m_err, m_rty}, 3'b000);
    chk("rst_m_dat", m_dat_r, 32'h0);
    chk("rst_s_adr", s_adr, 32'h1234_5678);
    chk("rst_s_dat", s_dat_w, 32'hA5A5_5A5A);
    chk("rst_s_sel_we", {s_sel, s_we}, 5'b0110_1);
    rst_n = 1'b1;
    step();

    // Table: decode, forward, respond, return to idle
    for (int v = 0; v < 9; v++) begin
      request(vecs[v].adr, vecs[v].we, vecs[v].wdat);
      settle();
      chk($sformatf("v%0d_idle_stb", v), s_stb, 2'b00);
      chk($sformatf("v%0d_idle_resp", v), {m_ack, m_err, m_rty}, 3'b000);
      chk($sformatf("v%0d_fanout", v), {s_adr, s_dat_w, s_we}, {vecs[v].adr, vecs[v].wdat, vecs[v].we});
      step();
      s_ack = vecs[v].sack; s_err = vecs[v].serr; s_rty = vecs[v].srty;
      s_dat_r = {vecs[v].sdat1, vecs[v].sdat0};
      settle();
      chk($sformatf("v%0d_s_stb", v), s_stb, vecs[v].exp_stb);
      chk($sformatf("v%0d_s_cyc", v), s_cyc, vecs[v].exp_stb);
      chk($sformatf("v%0d_m_ack", v), m_ack, vecs[v].exp_ack);
      chk($sformatf("v%0d_m_err", v), m_err, vecs[v].exp_err);
      chk($sformatf("v%0d_m_rty", v), m_rty, vecs[v].exp_rty);
      chk($sformatf("v%0d_m_dat", v), m_dat_r, vecs[v].exp_dat);
      step();
      bus_idle();
      settle();
      chk($sformatf("v%0d_after_resp", v), {m_ack, m_err, m_rty}, 3'b000);
      chk($sformatf("v%0d_after_stb", v), s_stb, 2'b00);
    end

    // Read with slave 0 answering on the third forward cycle
    request(32'h1000_0004, 1'b0, 32'h0);
    step();
    for (int c = 0; c < 2; c++) begin
      settle();
      chk($sformatf("late_wait%0d_stb", c), s_stb, 2'b01);
      chk($sformatf("late_wait%0d_ack", c), m_ack, 1'b0);
      step();
    end
    s_ack = 2'b01; s_dat_r = {32'h0, 32'hDEAD_BEEF};
    settle();
    chk("late_ack", m_ack, 1'b1);
    chk("late_dat", m_dat_r, 32'hDEAD_BEEF);
    chk("late_stb1", s_stb[1], 1'b0);
    step();
    bus_idle();
    settle();
    chk("late_ack_done", m_ack, 1'b0);
    chk("late_dat_idle", m_dat_r, 32'h0);
    step();

    // Timeout: slave 0 silent, slave 1 acking is ignored
    request(32'h1000_0000, 1'b0, 32'h0);
    s_ack = 2'b10;
    step();
    for (int c = 0; c < 4; c++) begin
      settle();
      chk($sformatf("to_fwd%0d_stb", c), s_stb, 2'b01);
      chk($sformatf("to_fwd%0d_resp", c), {m_ack, m_err, m_rty}, 3'b000);
      step();
    end
    settle();
    chk("to_drop_stb", s_stb, 2'b00);
    chk("to_drop_err", m_err, 1'b0);
    step();
    settle();
    chk("to_derr_err", m_err, 1'b1);
    chk("to_derr_stb", s_stb, 2'b00);
    chk("to_derr_dat", m_dat_r, 32'h0);
    step();
    bus_idle();
    settle();
    chk("to_idle_err", m_err, 1'b0);
    step();

    // Master abandons the cycle in forward cycle 2
    request(32'h4000_0000, 1'b1, 32'h3);
    step();
    settle();
    chk("drop_fwd1_stb", s_stb, 2'b10);
    step();
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = 2'b10;
    settle();
    chk("drop_stb", {s_cyc, s_stb}, 4'b0000);
    chk("drop_resp", {m_ack, m_err}, 2'b00);
    step();
    settle();
    chk("drop_after_resp", {m_ack, m_err}, 2'b00);
    s_ack = 2'b00;
    request(32'h1000_0004, 1'b0, 32'h0);
    settle();
    chk("drop_idle_stb", s_stb, 2'b00);
    step();
    settle();
    chk("drop_new_stb", s_stb, 2'b01);
    step();
    bus_idle();
    step();

    // Reset pulse in the middle of a forward
    request(32'h4000_0000, 1'b0, 32'h0);
    step();
    settle();
    chk("rstmid_fwd_stb", s_stb, 2'b10);
    s_ack = 2'b10; rst_n = 1'b0;
    settle();
    chk("rstmid_stb", s_stb, 2'b00);
    chk("rstmid_resp", {m_ack, m_err}, 2'b00);
    step();
    rst_n = 1'b1;
    settle();
    chk("rstmid_held_resp", {m_ack, m_err}, 2'b00);
    chk("rstmid_idle_stb", s_stb, 2'b00);
    step();
    settle();
    chk("rstmid_restart_stb", s_stb, 2'b10);
    step();
    bus_idle();
    step();
    step();

    // Overlapping regions: lowest index wins
    request(32'h1000_0010, 1'b0, 32'h0);
    step();
    s_ack = 2'b01;
    settle();
    chk("ovl_low_wins", o_s_stb, 2'b01);
    step();
    bus_idle();
    step();
    request(32'h1000_8000, 1'b0, 32'h0);
    step();
    settle();
    chk("ovl_only_hi", o_s_stb, 2'b10);
    chk("ovl_main_err", m_err, 1'b1);
    step();
    bus_idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_decoder.md
WB_DECODER -- requirements
Module: wb_decoder

Interface
REQ-001 SHALL have parameter N_SLAVES, default 2, number of slave ports (1..8).
REQ-002 SHALL have parameter SLAVE_BASE, default {32'h4000_0000, 32'h1000_0000}, flat N_SLAVES*32 region base addresses, slave 0 in LSBs.
REQ-003 SHALL have parameter SLAVE_MASK, default {32'hFFFF_F000, 32'hFFFF_F800}, flat N_SLAVES*32 region masks; hit when (adr & mask) == base.
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum wait cycles for a slave response (1..65535).
REQ-005 SHALL have ports: clk_i in 1, clock.
REQ-006 SHALL have ports: rst_ni in 1, asynchronous active-low reset.
REQ-007 SHALL have master-side inputs: m_cyc_i 1, m_stb_i 1, m_adr_i 32, m_sel_i 4, m_dat_i 32, m_we_i 1 (from CPU).
REQ-008 SHALL have master-side outputs: m_dat_o 32, m_ack_o 1, m_err_o 1, m_rty_o 1 (to CPU).
REQ-009 SHALL have slave-side outputs: s_cyc_o N_SLAVES, s_stb_o N_SLAVES, s_adr_o 32, s_sel_o 4, s_dat_o 32, s_we_o 1.
REQ-010 SHALL have slave-side inputs: s_dat_i N_SLAVES*32, s_ack_i, s_err_i, s_rty_i N_SLAVES each.

Function
REQ-011 SHALL fan out adr/sel/dat/we to all slaves unmodified, combinationally.
REQ-012 SHALL implement FSM IDLE, FWD, DERR.
REQ-013 IDLE: on m_cyc_i & m_stb_i, decode address; lowest-index hit wins on overlap; register slave index; go FWD next cycle; no hit -> DERR.
REQ-014 IDLE: all s_cyc_o/s_stb_o low, all m_* responses low.
REQ-015 FWD: s_cyc_o/s_stb_o asserted only for registered slave, gated combinationally by m_cyc_i & m_stb_i.
REQ-016 FWD: m_ack_o/m_err_o/m_rty_o/m_dat_o driven combinationally from registered slave only; other slaves' responses ignored.
REQ-017 FWD: first cycle with any response from selected slave -> IDLE next cycle; one transfer per request.
REQ-018 FWD: wait counter reset on entry, increments each non-response cycle; on reaching TIMEOUT with no response, slave strobes drop that cycle and FSM goes DERR.
REQ-019 DERR: m_err_o high exactly one cycle, m_dat_o = 0, no slave strobed, then IDLE.
REQ-020 Master drops m_cyc_i in FWD or DERR -> slave strobes and responses low same cycle, IDLE next cycle.
REQ-021 Added latency: exactly one cycle (decode register) versus a direct slave connection.
REQ-022 m_dat_o SHALL be 0 whenever no response is asserted.

Reset
REQ-023 rst_ni low SHALL asynchronously force IDLE, counter 0, slave index 0; all outputs low/zero except fan-out passthroughs.
REQ-024 Reset mid-FWD SHALL abort transaction with no response to master.

Structure
REQ-025 FSM state enum and default memory-map constants (RAM base 0x1000_0000 size 0x800, GPIO base 0x4000_0000) SHALL live in shared package soc_pkg.
REQ-026 Address-hit priority encoder SHALL be sub-module wb_addr_decode (combinational, parameterised on N_SLAVES/BASE/MASK).

Verification
REQ-027 Read 0x1000_0004, slave 0 acks after 2 cycles with 0xDEAD_BEEF -> m_ack_o one cycle, m_dat_o 0xDEAD_BEEF, s_stb_o[1] never high.
REQ-028 Write 0x4000_0000 dat 0x3 sel 0xF -> only s_stb_o[1] high, s_dat_o 0x3, m_ack_o mirrors s_ack_i[1].
REQ-029 Access 0x2000_0000 (unmapped) -> m_err_o high one cycle, 2 cycles after request; no s_stb_o.
REQ-030 TIMEOUT=4, slave never responds -> s_stb_o drops after 4 FWD cycles, m_err_o one cycle, then IDLE.
REQ-031 m_cyc_i dropped in FWD cycle 2 and rst_ni pulsed mid-FWD -> strobes low same cycle, no m_ack_o/m_err_o, FSM IDLE.
